// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the cache/memory control path.
// Holds the RAM handshake state encoding and the default RAM latency.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int RAM_LAT_DEFAULT   = 2;
    localparam int RAM_DEPTH_DEFAULT = 1024;

    // Byte address not on a word boundary
    function automatic logic ram_misaligned(input word_t addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Word storage behind the RAM responder.
// Synchronous write, asynchronous read, single shared address.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH_DEFAULT,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  word_t         wdata_i,
    output word_t         rdata_o
);

    word_t mem_q [DEPTH];

    // Commit a write at the end of the cycle it is enabled in
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ram_ctrl.sv
// Fixed-latency, word-addressed RAM responder for the memory controller.
// Reports FREE/BUSY/ACCESS/ERROR every cycle and serves one word per ACCESS.
module ram_ctrl
    import cpu_types_pkg::*;
#(
    parameter int LAT   = RAM_LAT_DEFAULT,
    parameter int DEPTH = RAM_DEPTH_DEFAULT
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_C   = 4'(LAT);
    localparam logic [30:0] DEPTH_C = 31'(DEPTH);

    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    word_t       last_addr_q;
    logic [1:0]  last_op_q;
    logic [1:0]  op;
    logic        req;
    logic        change;
    logic [3:0]  eff;
    logic        bad_addr;
    ramstate_t   state;
    logic        wr_en;
    word_t       rd_data;
    logic [AW-1:0] word_idx;

    assign op       = {ramREN, ramWEN};
    assign req      = ramREN | ramWEN;
    assign word_idx = ramaddr[AW+1:2];

    // A new address or operation discards any latency already served
    assign change = (ramaddr != last_addr_q) || (op != last_op_q);
    assign eff    = change ? 4'd0 : cnt_q;

    assign bad_addr = ram_misaligned(ramaddr)
                   || ({1'b0, ramaddr[31:2]} >= DEPTH_C);

    // Decode the handshake state; reset forces FREE without waiting for a clock
    always_comb begin
        state = FREE;
        if (!nRST) begin
            state = FREE;
        end else if (ramREN && ramWEN) begin
            state = ERROR;
        end else if (req && bad_addr) begin
            state = ERROR;
        end else if (!req) begin
            state = FREE;
        end else if (eff < LAT_C) begin
            state = BUSY;
        end else begin
            state = ACCESS;
        end
    end

    // Count served latency only while a request is waiting
    always_comb begin
        cnt_d = 4'd0;
        if (state == BUSY) begin
            cnt_d = eff + 4'd1;
        end
    end

    // Latency counter and last-request history
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q       <= 4'd0;
            last_addr_q <= '0;
            last_op_q   <= 2'b00;
        end else begin
            cnt_q       <= cnt_d;
            last_addr_q <= ramaddr;
            last_op_q   <= op;
        end
    end

    assign wr_en = (state == ACCESS) && ramWEN;

    ram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (wr_en),
        .addr_i  (word_idx),
        .wdata_i (ramstore),
        .rdata_o (rd_data)
    );

    assign ramload  = ((state == ACCESS) && ramREN) ? rd_data : '0;
    assign ramstate = state;

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl against a request-streak memory model.
// Covers directed handshake scenarios, random traffic, and a zero-latency instance.
module tb_ram_ctrl;
    import cpu_types_pkg::*;

    localparam int LAT   = RAM_LAT_DEFAULT;
    localparam int DEPTH = 1024;

    logic      CLK = 1'b0;
    logic      nRST = 1'b0;
    logic      ramREN = 1'b0;
    logic      ramWEN = 1'b0;
    word_t     ramaddr = '0;
    word_t     ramstore = '0;
    word_t     ramload;
    ramstate_t ramstate;

    logic      ren0 = 1'b0;
    logic      wen0 = 1'b0;
    word_t     addr0 = '0;
    word_t     store0 = '0;
    word_t     load0;
    ramstate_t state0;

    int vectors = 0;
    int errors  = 0;

    // Model: words written so far, plus how many cycles the current
    // identical request has already waited since it was first seen.
    word_t mem_m [int unsigned];
    int    waited = 0;
    logic  prev_ok = 1'b0;
    logic  prev_r = 1'b0;
    logic  prev_w = 1'b0;
    word_t prev_a = '0;

    always #5 CLK = ~CLK;

    ram_ctrl #(
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) u_dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    ram_ctrl #(
        .LAT   (0),
        .DEPTH (DEPTH)
    ) u_dut0 (
        .CLK      (CLK),
        .nRST     (nRST),
        .ramREN   (ren0),
        .ramWEN   (wen0),
        .ramaddr  (addr0),
        .ramstore (store0),
        .ramload  (load0),
        .ramstate (state0)
    );

    task automatic chk(input string tag, input word_t got, input word_t exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle on the main instance: drive, check mid-cycle, advance model
    task automatic cyc(input string tag, input logic rst_v, input logic r,
                       input logic w, input word_t a, input word_t d);
        ramstate_t e;
        logic      req;
        logic      bad;
        int        n;
        word_t     eload;
        logic      known;
        int unsigned idx;
        nRST = rst_v; ramREN = r; ramWEN = w; ramaddr = a; ramstore = d;
        req = r | w;
        idx = a >> 2;
        bad = (r && w) || (req && ((a[1:0] != 2'b00) || (idx >= DEPTH)));
        n = (prev_ok && prev_r == r && prev_w == w && prev_a == a) ? waited : 0;
        if (!rst_v)        e = FREE;
        else if (bad)      e = ERROR;
        else if (!req)     e = FREE;
        else if (n < LAT)  e = BUSY;
        else               e = ACCESS;
        known = 1'b1;
        eload = '0;
        if (e == ACCESS && r) begin
            if (mem_m.exists(idx)) eload = mem_m[idx];
            else known = 1'b0;
        end
        @(negedge CLK);
        chk({tag, ".state"}, 32'(ramstate), 32'(e));
        if (known) chk({tag, ".load"}, ramload, eload);
        @(posedge CLK);
        if (!rst_v) begin
            prev_ok = 1'b0;
            waited  = 0;
        end else begin
            prev_ok = 1'b1;
            prev_r  = r;
            prev_w  = w;
            prev_a  = a;
            waited  = (e == BUSY) ? n + 1 : 0;
            if (e == ACCESS && w) mem_m[idx] = d;
        end
        #1;
    endtask

    // Hold one request for a number of cycles
    task automatic hold(input string tag, input logic r, input logic w,
                        input word_t a, input word_t d, input int len);
        for (int i = 0; i < len; i++) cyc(tag, 1'b1, r, w, a, d);
    endtask

    // One cycle on the zero-latency instance with fixed expectations
    task automatic cyc0(input string tag, input logic r, input logic w,
                        input word_t a, input word_t d,
                        input ramstate_t es, input word_t el);
        ren0 = r; wen0 = w; addr0 = a; store0 = d;
        @(negedge CLK);
        chk({tag, ".state"}, 32'(state0), 32'(es));
        chk({tag, ".load"}, load0, el);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic r;
        logic w;
        word_t a;
        word_t d;
        int k;
        word_t pool [6];
        pool[0] = 32'h40;  pool[1] = 32'h44;  pool[2] = 32'h80;
        pool[3] = 32'h84;  pool[4] = 32'h100; pool[5] = 32'hFFC;

        // Reset: FREE and no load while held low
        #2;
        chk("rst.state", 32'(ramstate), 32'(FREE));
        chk("rst.load", ramload, 32'h0);
        @(posedge CLK);
        #1;
        cyc("rst", 1'b0, 1'b0, 1'b0, '0, '0);
        cyc("idle", 1'b1, 1'b0, 1'b0, '0, '0);

        // Write then read back 0x40
        hold("wr40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 3);
        hold("rd40", 1'b1, 1'b0, 32'h40, '0, 3);

        // Address change mid-BUSY restarts latency
        hold("wr84", 1'b0, 1'b1, 32'h84, 32'h84848484, 3);
        cyc("rd80", 1'b1, 1'b1, 1'b0, 32'h80, '0);
        hold("rd84", 1'b1, 1'b0, 32'h84, '0, 3);

        // Illegal requests
        hold("wr10", 1'b0, 1'b1, 32'h10, 32'h10101010, 3);
        hold("both", 1'b1, 1'b1, 32'h10, 32'hBAD0BAD0, 3);
        hold("mis", 1'b0, 1'b1, 32'h42, 32'hBAD1BAD1, 3);
        hold("oor", 1'b0, 1'b1, 32'h1000, 32'hBAD2BAD2, 3);
        hold("rd10", 1'b1, 1'b0, 32'h10, '0, 3);

        // Two-beat block writeback, then read both beats
        hold("wb0", 1'b0, 1'b1, 32'h100, 32'h11111111, 3);
        hold("wb1", 1'b0, 1'b1, 32'h104, 32'h22222222, 3);
        hold("rb0", 1'b1, 1'b0, 32'h100, '0, 3);
        hold("rb1", 1'b1, 1'b0, 32'h104, '0, 3);

        // Reset mid-BUSY blocks the write; held request restarts
        hold("pre200", 1'b0, 1'b1, 32'h200, 32'h0BADF00D, 3);
        cyc("w200", 1'b1, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D);
        cyc("w200rst", 1'b0, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D);
        hold("r200old", 1'b1, 1'b0, 32'h200, '0, 3);
        hold("w200b", 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 3);
        hold("r200new", 1'b1, 1'b0, 32'h200, '0, 3);

        // Dropping a request mid-BUSY
        hold("drop", 1'b0, 1'b1, 32'h44, 32'h44444444, 2);
        cyc("drop.free", 1'b1, 1'b0, 1'b0, 32'h44, '0);
        hold("rd44", 1'b1, 1'b0, 32'h44, '0, 3);

        // Random traffic with random hold lengths and rare resets
        for (int i = 0; i < 120; i++) begin
            k = $urandom_range(0, 19);
            a = pool[$urandom_range(0, 5)];
            d = $urandom;
            r = $urandom_range(0, 1) == 1;
            w = !r;
            if (k == 0) begin r = 1'b1; w = 1'b1; end
            if (k == 1) a = a + 32'h2;
            if (k == 2) a = a + 32'h2000;
            if (k == 3) begin r = 1'b0; w = 1'b0; end
            if (k == 4) cyc("rnd.rst", 1'b0, r, w, a, d);
            else hold("rnd", r, w, a, d, $urandom_range(1, LAT + 3));
        end
        cyc("end.idle", 1'b1, 1'b0, 1'b0, '0, '0);

        // Zero latency: ACCESS in the request cycle, FREE when dropped
        cyc0("l0.wr", 1'b0, 1'b1, 32'h0, 32'h12345678, ACCESS, 32'h0);
        cyc0("l0.rd0", 1'b1, 1'b0, 32'h0, '0, ACCESS, 32'h12345678);
        cyc0("l0.rd1", 1'b1, 1'b0, 32'h0, '0, ACCESS, 32'h12345678);
        cyc0("l0.rd2", 1'b1, 1'b0, 32'h0, '0, ACCESS, 32'h12345678);
        cyc0("l0.drop", 1'b0, 1'b0, 32'h0, '0, FREE, 32'h0);
        cyc0("l0.err", 1'b1, 1'b1, 32'h0, '0, ERROR, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
